// File: rtl/pipeline_pkg.sv
// Shared types for the number pipeline stages.
// Handshake: prev_valid flows in from upstream and this_ready flows back to it.
// this_valid flows out to downstream and next_ready flows back from it.
// A word moves across an interface at a rising clk edge when valid & ready.
package pipeline_pkg;

  localparam int NUM_WIDTH = 5;

  typedef logic [NUM_WIDTH-1:0] num_t;

endpackage

// File: rtl/fifo_stage_mem.sv
// DEPTH x WIDTH storage for fifo_stage: one write port, one asynchronous read port.
// Entries are not reset; the stage never shows an entry it has not written.
module fifo_stage_mem
  import pipeline_pkg::*;
#(
  parameter int WIDTH  = NUM_WIDTH,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fifo_stage.sv
// Elastic first-word-fall-through buffer between pipeline stages.
// this_ready depends only on reset and registered occupancy, never on next_ready.
module fifo_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = NUM_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prev_valid,
  output logic                       this_ready,
  output logic                       this_valid,
  input  logic                       next_ready,
  input  logic [WIDTH-1:0]           input_num,
  output logic [WIDTH-1:0]           output_num,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] head_s;

  assign this_ready = !reset && (count_r != CNT_W'(DEPTH));
  assign this_valid = (count_r != {CNT_W{1'b0}});
  assign push_s     = prev_valid && this_ready;
  assign pop_s      = this_valid && next_ready;
  assign count      = count_r;
  assign output_num = this_valid ? head_s : {WIDTH{1'b0}};

  fifo_stage_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push_s),
    .wr_addr(wr_ptr_r),
    .wr_data(input_num),
    .rd_addr(rd_ptr_r),
    .rd_data(head_s)
  );

  // next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // pointer and occupancy registers; pointers wrap modulo DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: tb/tb_fifo_stage.sv
// Directed self-checking bench for fifo_stage (WIDTH=5, DEPTH=4).
module tb_fifo_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       prev_valid;
  logic       this_ready;
  logic       this_valid;
  logic       next_ready;
  logic [4:0] input_num;
  logic [4:0] output_num;
  logic [2:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_stage #(.WIDTH(5), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .prev_valid(prev_valid),
    .this_ready(this_ready),
    .this_valid(this_valid),
    .next_ready(next_ready),
    .input_num (input_num),
    .output_num(output_num),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input int unsigned num, input logic nr);
    prev_valid = pv;
    input_num  = 5'(num);
    next_ready = nr;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int q[$];
    int in_idx;
    int out_idx;
    int cyc;
    bit pat[6];
    bit m_push;
    bit m_pop;

    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    reset = 1'b1;
    drive(1'b0, 0, 1'b0);
    #2;
    check("rst_ready",  this_ready, 0);
    check("rst_valid",  this_valid, 0);
    check("rst_count",  count,      0);
    check("rst_out",    output_num, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rel_ready", this_ready, 1);

    // 1: pass-through 1,2,3
    drive(1'b1, 1, 1'b1); tick();
    check("t1_out1", output_num, 1); check("t1_cnt1", count, 1);
    drive(1'b1, 2, 1'b1); tick();
    check("t1_out2", output_num, 2); check("t1_cnt2", count, 1);
    drive(1'b1, 3, 1'b1); tick();
    check("t1_out3", output_num, 3); check("t1_cnt3", count, 1);
    drive(1'b0, 0, 1'b1); tick();
    check("t1_valid_fall", this_valid, 0); check("t1_cnt0", count, 0);
    check("t1_out0", output_num, 0);

    // 2: fill while stalled, 9 held upstream
    for (int v = 5; v <= 8; v++) begin
      drive(1'b1, v, 1'b0); tick();
      check("t2_fill_cnt", count, v - 4);
    end
    check("t2_full_ready", this_ready, 0);
    drive(1'b1, 9, 1'b0); tick();
    check("t2_hold_cnt", count, 4); check("t2_hold_out", output_num, 5);
    check("t2_hold_valid", this_valid, 1);
    drive(1'b1, 9, 1'b1); tick();
    check("t2_pop_cnt", count, 3); check("t2_out6", output_num, 6);
    check("t2_ready_back", this_ready, 1);
    drive(1'b1, 9, 1'b1); tick();
    check("t2_push9_cnt", count, 3); check("t2_out7", output_num, 7);
    drive(1'b0, 0, 1'b1); tick();
    check("t2_out8", output_num, 8);
    tick();
    check("t2_out9", output_num, 9); check("t2_cnt1", count, 1);
    tick();
    check("t2_empty", count, 0);

    // 3: full with pop and offered push
    for (int v = 10; v <= 13; v++) begin
      drive(1'b1, v, 1'b0); tick();
    end
    check("t3_full", count, 4);
    drive(1'b1, 14, 1'b1); tick();
    check("t3_cnt", count, 3); check("t3_out", output_num, 11);
    check("t3_ready", this_ready, 1);

    // 4: simultaneous push and pop at count=2
    drive(1'b0, 0, 1'b1); tick();
    check("t4_pre_cnt", count, 2); check("t4_pre_out", output_num, 12);
    drive(1'b1, 15, 1'b1); tick();
    check("t4_cnt", count, 2); check("t4_head", output_num, 13);
    drive(1'b0, 0, 1'b1); tick();
    check("t4_tail", output_num, 15); check("t4_cnt1", count, 1);
    tick();
    check("t4_empty", count, 0);

    // 5: stream 0..19 against a queue model, next_ready pattern 1,1,0,1,0,0
    in_idx = 0; out_idx = 0; cyc = 0;
    while (out_idx < 20 && cyc < 300) begin
      drive(in_idx < 20, in_idx, pat[cyc % 6]);
      check("t5_ready", this_ready, (q.size() != 4) ? 1 : 0);
      check("t5_valid", this_valid, (q.size() != 0) ? 1 : 0);
      check("t5_head",  output_num, (q.size() != 0) ? q[0] : 0);
      m_push = (in_idx < 20) && (q.size() != 4);
      m_pop  = (q.size() != 0) && pat[cyc % 6];
      if (m_pop) begin
        check("t5_order", output_num, out_idx % 32);
        void'(q.pop_front());
        out_idx++;
      end
      if (m_push) begin
        q.push_back(in_idx % 32);
        in_idx++;
      end
      tick();
      check("t5_count", count, q.size());
      cyc++;
    end
    check("t5_all_out", out_idx, 20);

    // 6: asynchronous reset between edges with count=3
    drive(1'b1, 21, 1'b0); tick();
    drive(1'b1, 22, 1'b0); tick();
    drive(1'b1, 23, 1'b0); tick();
    drive(1'b0, 0, 1'b0);
    check("t6_pre_cnt", count, 3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", this_valid, 0); check("t6_cnt", count, 0);
    check("t6_out", output_num, 0);   check("t6_ready", this_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    check("t6_rel_ready", this_ready, 1); check("t6_rel_valid", this_valid, 0);
    drive(1'b1, 17, 1'b0); tick();
    check("t6_first", output_num, 17); check("t6_first_cnt", count, 1);
    drive(1'b0, 0, 1'b1); tick();
    check("t6_drain", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
